hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline interlock and forwarding controller for the 5-stage RV32I core. Tracks destination
//  registers of in-flight instructions (EX, MA, WB), registers the forwarding-hit selects the EX
//  stage uses to pick rd_data_ma / wbk_data_wb / wbk_data_wb2, and sequences stalls for load-use
//  hazards and data-memory wait states. Sits beside ID; drives stall/bubble into IF, ID and EX.
// PARAMETERS
//  ADR_W        5    register address width
//  WAIT_TIMEOUT 255  max consecutive dmem_busy cycles before mem_timeout asserts (1..255)
// PORTS
//  clk              in   1      core clock
//  rst              in   1      asynchronous, active-high reset
//  rs1_adr_id       in   ADR_W  rs1 address of instruction in ID
//  rs2_adr_id       in   ADR_W  rs2 address of instruction in ID
//  use_rs1_id       in   1      ID instruction reads rs1
//  use_rs2_id       in   1      ID instruction reads rs2
//  rd_adr_id        in   ADR_W  rd address of ID instruction
//  wbk_rd_reg_id    in   1      ID instruction writes rd
//  cmd_ld_id        in   1      ID instruction is a load
//  jmp_purge        in   1      EX taken jump/ecall: ID instruction is killed this cycle
//  dmem_busy        in   1      data memory cannot accept/return this cycle
//  rst_pipe         in   1      synchronous pipeline flush
//  hit_rs{1,2}_idex_ex out 1    forward from rd_data_ma
//  hit_rs{1,2}_idma_ex out 1    forward from wbk_data_wb
//  hit_rs{1,2}_idwb_ex out 1    forward from wbk_data_wb2
//  nohit_rs{1,2}_ex    out 1    use register-file data
//  stall            out  1      global freeze of all pipeline FFs
//  stall_id         out  1      freeze IF/ID only (load-use)
//  bubble_ex        out  1      inject NOP into ID->EX register
//  mem_timeout      out  1      sticky: dmem_busy exceeded WAIT_TIMEOUT
// BEHAVIOUR
//  Reset: all hit_* 0, nohit_* 1, stall/stall_id/bubble_ex/mem_timeout 0, FSM RUN, tracker empty.
//  Tracker: 3-entry shift {rd, wr_valid, is_ld} for EX, MA, WB; shifts on ~stall & ~stall_id
//   (EX entry loads ID info, or zero when bubble_ex|jmp_purge); on stall_id only EX<-0, rest shift.
//  Hit regs: computed from ID sources vs tracker, registered on the same enable -> valid in EX
//   one cycle later. Priority youngest first: EX entry -> idex, MA -> idma, WB -> idwb.
//   Exactly one of hit_idex/idma/idwb/nohit is 1 per source. rd==0 or use_rsN_id==0 -> nohit.
//  Load-use: ID source matches EX entry with is_ld & wr_valid & rd!=0 & ~jmp_purge -> 1 bubble.
//  FSM states: RUN, LDUSE, MWAIT.
//   RUN  : dmem_busy -> MWAIT (stall=1 same cycle, comb); else load-use -> LDUSE.
//   LDUSE: stall_id=1, bubble_ex=1 for exactly 1 cycle; next RUN (MWAIT if dmem_busy, which wins).
//   MWAIT: stall=1 while dmem_busy; counter++ saturating; count==WAIT_TIMEOUT -> mem_timeout=1
//          (sticky until rst). dmem_busy low -> RUN, counter cleared, stall drops that cycle.
//  stall = dmem_busy (comb, any state); stall_id/bubble_ex only in LDUSE and only if ~stall.
//  rst_pipe: highest sync priority; tracker cleared, hit regs -> nohit, FSM -> RUN, counter 0;
//   mem_timeout preserved. Async rst mid-MWAIT/LDUSE returns everything to reset values.
//  Simultaneous: load-use pending + dmem_busy -> MWAIT first, load-use re-evaluated after.
//   jmp_purge with load-use -> no bubble. Pair of same-rd writes -> youngest wins.
// STRUCTURE
//  hazard_pkg: state enum {RUN, LDUSE, MWAIT}, tracker entry struct, ADR_W default.
//  One sub-module hazard_src_sel (per-source compare+priority; instantiated for rs1, rs2).
// TESTING
//  ADD x5 then ADD x6,x5 -> next cycle hit_rs1_idex_ex=1, others 0, no stall.
//  LW x7, then 1 gap, then SUB x8,x7,x7 -> hit_rs1_idma_ex=hit_rs2_idma_ex=1, no bubble.
//  LW x7 then ADD x9,x7 -> stall_id=1,bubble_ex=1 for 1 cycle, then hit_rs1_idma_ex=1.
//  Writes to x0 in EX/MA/WB, reader of x0 -> nohit=1 always; load to x0 -> no bubble.
//  dmem_busy held 3 cycles -> stall=1 for 3 cycles, tracker frozen; WAIT_TIMEOUT=4, busy 5 cycles -> mem_timeout=1.
//  Load-use with jmp_purge=1 same cycle -> no bubble; rst_pipe in LDUSE -> RUN, all nohit next cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the interlock/forwarding controller.
package hazard_pkg;

    localparam int ADR_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LDUSE = 2'd1,
        ST_MWAIT = 2'd2
    } state_t;

    // EX entry needs the load flag; older entries only feed forwarding.
    typedef struct packed {
        logic [ADR_W_DEF-1:0] rd;
        logic                 wr;
        logic                 ld;
    } trk_ent_t;

    typedef struct packed {
        logic [ADR_W_DEF-1:0] rd;
        logic                 wr;
    } fwd_ent_t;

    typedef struct packed {
        logic nohit;
        logic idwb;
        logic idma;
        logic idex;
    } hit_t;

    localparam hit_t HIT_NONE = '{nohit: 1'b1, idwb: 1'b0,
                                  idma: 1'b0, idex: 1'b0};

endpackage

// File: rtl/hazard_src_sel.sv
// Per-source compare against the in-flight tracker, youngest match wins.
module hazard_src_sel
    import hazard_pkg::*;
(
    input  logic [ADR_W_DEF-1:0] adr,
    input  logic                 use_rs,
    input  trk_ent_t             ex,
    input  fwd_ent_t             ma,
    input  fwd_ent_t             wb,
    output hit_t                 sel,
    output logic                 ld_hit
);

    logic live;
    logic h_ex;
    logic h_ma;
    logic h_wb;

    assign live = use_rs & (|adr);
    assign h_ex = live & ex.wr & (ex.rd == adr);
    assign h_ma = live & ma.wr & (ma.rd == adr);
    assign h_wb = live & wb.wr & (wb.rd == adr);

    assign sel.idex  = h_ex;
    assign sel.idma  = ~h_ex & h_ma;
    assign sel.idwb  = ~h_ex & ~h_ma & h_wb;
    assign sel.nohit = ~(h_ex | h_ma | h_wb);

    assign ld_hit = h_ex & ex.ld;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / memory-wait interlock and registered forwarding selects
// for the EX stage of the 5-stage core.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int ADR_W        = ADR_W_DEF,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADR_W-1:0] rs1_adr_id,
    input  logic [ADR_W-1:0] rs2_adr_id,
    input  logic             use_rs1_id,
    input  logic             use_rs2_id,
    input  logic [ADR_W-1:0] rd_adr_id,
    input  logic             wbk_rd_reg_id,
    input  logic             cmd_ld_id,
    input  logic             jmp_purge,
    input  logic             dmem_busy,
    input  logic             rst_pipe,
    output logic             hit_rs1_idex_ex,
    output logic             hit_rs1_idma_ex,
    output logic             hit_rs1_idwb_ex,
    output logic             nohit_rs1_ex,
    output logic             hit_rs2_idex_ex,
    output logic             hit_rs2_idma_ex,
    output logic             hit_rs2_idwb_ex,
    output logic             nohit_rs2_ex,
    output logic             stall,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             mem_timeout
);

    localparam logic [7:0] TMO = 8'(WAIT_TIMEOUT);

    trk_ent_t trk_ex;
    trk_ent_t trk_in;
    fwd_ent_t trk_ma;
    fwd_ent_t trk_wb;
    fwd_ent_t ex_fwd;
    hit_t     sel1;
    hit_t     sel2;
    hit_t     hit1_q;
    hit_t     hit2_q;
    logic     ld1;
    logic     ld2;
    logic     ldu;
    logic     en;
    state_t   state_q;
    state_t   state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_inc;

    hazard_src_sel u_sel_rs1 (
        .adr    (rs1_adr_id),
        .use_rs (use_rs1_id),
        .ex     (trk_ex),
        .ma     (trk_ma),
        .wb     (trk_wb),
        .sel    (sel1),
        .ld_hit (ld1)
    );

    hazard_src_sel u_sel_rs2 (
        .adr    (rs2_adr_id),
        .use_rs (use_rs2_id),
        .ex     (trk_ex),
        .ma     (trk_ma),
        .wb     (trk_wb),
        .sel    (sel2),
        .ld_hit (ld2)
    );

    // A killed ID instruction can never need its load result.
    assign ldu = (ld1 | ld2) & ~jmp_purge;

    // LDUSE marks that the single bubble for this hazard was issued.
    assign stall     = dmem_busy;
    assign stall_id  = ~dmem_busy & ldu & (state_q != ST_LDUSE);
    assign bubble_ex = stall_id;
    assign en        = ~dmem_busy & ~stall_id;

    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        trk_in.rd = rd_adr_id;
        trk_in.wr = wbk_rd_reg_id;
        trk_in.ld = cmd_ld_id;
        ex_fwd.rd = trk_ex.rd;
        ex_fwd.wr = trk_ex.wr;
    end

    always_comb begin
        state_d = ST_RUN;
        if (dmem_busy) begin
            state_d = ST_MWAIT;
        end else if (stall_id) begin
            state_d = ST_LDUSE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trk_ex      <= '0;
            trk_ma      <= '0;
            trk_wb      <= '0;
            hit1_q      <= HIT_NONE;
            hit2_q      <= HIT_NONE;
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            mem_timeout <= 1'b0;
        end else if (rst_pipe) begin
            trk_ex  <= '0;
            trk_ma  <= '0;
            trk_wb  <= '0;
            hit1_q  <= HIT_NONE;
            hit2_q  <= HIT_NONE;
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= dmem_busy ? cnt_inc : '0;
            if (dmem_busy && (cnt_inc >= TMO)) begin
                mem_timeout <= 1'b1;
            end
            if (en) begin
                trk_ex <= jmp_purge ? '0 : trk_in;
                trk_ma <= ex_fwd;
                trk_wb <= trk_ma;
                hit1_q <= sel1;
                hit2_q <= sel2;
            end else if (!dmem_busy) begin
                trk_ex <= '0;
                trk_ma <= ex_fwd;
                trk_wb <= trk_ma;
            end
        end
    end

    assign hit_rs1_idex_ex = hit1_q.idex;
    assign hit_rs1_idma_ex = hit1_q.idma;
    assign hit_rs1_idwb_ex = hit1_q.idwb;
    assign nohit_rs1_ex    = hit1_q.nohit;
    assign hit_rs2_idex_ex = hit2_q.idex;
    assign hit_rs2_idma_ex = hit2_q.idma;
    assign hit_rs2_idwb_ex = hit2_q.idwb;
    assign nohit_rs2_ex    = hit2_q.nohit;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (WAIT_TIMEOUT = 4).
module tb_hazard_ctrl;

    localparam logic [3:0] NH = 4'b1000;
    localparam logic [3:0] HW = 4'b0100;
    localparam logic [3:0] HM = 4'b0010;
    localparam logic [3:0] HE = 4'b0001;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_adr_id;
    logic [4:0] rs2_adr_id;
    logic       use_rs1_id;
    logic       use_rs2_id;
    logic [4:0] rd_adr_id;
    logic       wbk_rd_reg_id;
    logic       cmd_ld_id;
    logic       jmp_purge;
    logic       dmem_busy;
    logic       rst_pipe;
    logic       hit_rs1_idex_ex;
    logic       hit_rs1_idma_ex;
    logic       hit_rs1_idwb_ex;
    logic       nohit_rs1_ex;
    logic       hit_rs2_idex_ex;
    logic       hit_rs2_idma_ex;
    logic       hit_rs2_idwb_ex;
    logic       nohit_rs2_ex;
    logic       stall;
    logic       stall_id;
    logic       bubble_ex;
    logic       mem_timeout;

    typedef struct {
        string      tag;
        logic [3:0] h1;
        logic [3:0] h2;
        logic       s;
        logic       sid;
        logic       to;
        logic       ck;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .ADR_W        (5),
        .WAIT_TIMEOUT (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rs1_adr_id      (rs1_adr_id),
        .rs2_adr_id      (rs2_adr_id),
        .use_rs1_id      (use_rs1_id),
        .use_rs2_id      (use_rs2_id),
        .rd_adr_id       (rd_adr_id),
        .wbk_rd_reg_id   (wbk_rd_reg_id),
        .cmd_ld_id       (cmd_ld_id),
        .jmp_purge       (jmp_purge),
        .dmem_busy       (dmem_busy),
        .rst_pipe        (rst_pipe),
        .hit_rs1_idex_ex (hit_rs1_idex_ex),
        .hit_rs1_idma_ex (hit_rs1_idma_ex),
        .hit_rs1_idwb_ex (hit_rs1_idwb_ex),
        .nohit_rs1_ex    (nohit_rs1_ex),
        .hit_rs2_idex_ex (hit_rs2_idex_ex),
        .hit_rs2_idma_ex (hit_rs2_idma_ex),
        .hit_rs2_idwb_ex (hit_rs2_idwb_ex),
        .nohit_rs2_ex    (nohit_rs2_ex),
        .stall           (stall),
        .stall_id        (stall_id),
        .bubble_ex       (bubble_ex),
        .mem_timeout     (mem_timeout)
    );

    task automatic chk(input string tag, input string nm,
                       input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s.%s observed=%b expected=%b", tag, nm, obs, exp);
        end
    endtask

    // One cycle: drive ID/control at negedge, sample 2ns later.
    task automatic cyc(input string tag,
                       input logic [4:0] a1, input logic u1,
                       input logic [4:0] a2, input logic u2,
                       input logic [4:0] rd, input logic wr, input logic ld,
                       input logic jp, input logic busy,
                       input logic rp, input logic r,
                       input logic [3:0] e1, input logic [3:0] e2,
                       input logic es, input logic esid, input logic eto,
                       input logic ck);
        exp_t e;
        @(negedge clk);
        rs1_adr_id    = a1;
        use_rs1_id    = u1;
        rs2_adr_id    = a2;
        use_rs2_id    = u2;
        rd_adr_id     = rd;
        wbk_rd_reg_id = wr;
        cmd_ld_id     = ld;
        jmp_purge     = jp;
        dmem_busy     = busy;
        rst_pipe      = rp;
        rst           = r;
        q.push_back('{tag: tag, h1: e1, h2: e2, s: es, sid: esid,
                      to: eto, ck: ck});
        #2;
        e = q.pop_front();
        if (e.ck) begin
            chk(e.tag, "rs1", {nohit_rs1_ex, hit_rs1_idwb_ex,
                               hit_rs1_idma_ex, hit_rs1_idex_ex}, e.h1);
            chk(e.tag, "rs2", {nohit_rs2_ex, hit_rs2_idwb_ex,
                               hit_rs2_idma_ex, hit_rs2_idex_ex}, e.h2);
        end
        chk(e.tag, "stall", {3'b0, stall}, {3'b0, e.s});
        chk(e.tag, "stall_id", {3'b0, stall_id}, {3'b0, e.sid});
        chk(e.tag, "bubble", {3'b0, bubble_ex}, {3'b0, e.sid});
        chk(e.tag, "tmo", {3'b0, mem_timeout}, {3'b0, e.to});
    endtask

    task automatic nop(input string tag, input logic busy,
                       input logic [3:0] e1, input logic [3:0] e2,
                       input logic es, input logic eto, input logic ck);
        cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, busy, 0, 0,
            e1, e2, es, 1'b0, eto, ck);
    endtask

    initial begin
        rst = 1'b1;
        {rs1_adr_id, rs2_adr_id, rd_adr_id} = '0;
        {use_rs1_id, use_rs2_id, wbk_rd_reg_id, cmd_ld_id} = '0;
        {jmp_purge, dmem_busy, rst_pipe} = '0;

        cyc("rst", 0,0, 0,0, 0,0,0, 0,0,0,1, NH,NH, 0,0,0, 1);
        // ADD x5 ; ADD x6,x5 ; SUB x8,x5,x6
        cyc("t1a", 1,1, 2,1, 5,1,0, 0,0,0,0, NH,NH, 0,0,0, 1);
        cyc("t1b", 5,1, 0,1, 6,1,0, 0,0,0,0, NH,NH, 0,0,0, 1);
        nop("t1c", 0, HE, NH, 0, 0, 1);
        cyc("t1d", 5,1, 6,1, 8,1,0, 0,0,0,0, NH,NH, 0,0,0, 1);
        nop("t1e", 0, HW, HM, 0, 0, 1);
        // LW x7 ; gap ; SUB x8,x7,x7
        cyc("t2a", 1,1, 0,0, 7,1,1, 0,0,0,0, NH,NH, 0,0,0, 1);
        nop("t2b", 0, NH, NH, 0, 0, 1);
        cyc("t2c", 7,1, 7,1, 8,1,0, 0,0,0,0, NH,NH, 0,0,0, 1);
        nop("t2d", 0, HM, HM, 0, 0, 1);
        // LW x7 ; ADD x9,x7,x3 -> one bubble
        cyc("t3a", 2,1, 0,0, 7,1,1, 0,0,0,0, NH,NH, 0,0,0, 1);
        cyc("t3b", 7,1, 3,1, 9,1,0, 0,0,0,0, NH,NH, 0,1,0, 1);
        cyc("t3c", 7,1, 3,1, 9,1,0, 0,0,0,0, NH,NH, 0,0,0, 1);
        nop("t3d", 0, HM, NH, 0, 0, 1);
        // x0 writers and readers
        cyc("t4a", 0,1, 0,0, 0,1,0, 0,0,0,0, NH,NH, 0,0,0, 1);
        cyc("t4b", 0,1, 0,0, 0,1,1, 0,0,0,0, NH,NH, 0,0,0, 1);
        cyc("t4c", 0,1, 0,1, 1,1,0, 0,0,0,0, NH,NH, 0,0,0, 1);
        nop("t4d", 0, NH, NH, 0, 0, 1);
        // dmem_busy for 3 cycles freezes the tracker
        cyc("t5a", 1,1, 0,0, 10,1,0, 0,1,0,0, NH,NH, 1,0,0, 1);
        cyc("t5b", 1,1, 0,0, 10,1,0, 0,1,0,0, NH,NH, 1,0,0, 1);
        cyc("t5c", 1,1, 0,0, 10,1,0, 0,1,0,0, NH,NH, 1,0,0, 1);
        cyc("t5d", 1,1, 0,0, 10,1,0, 0,0,0,0, NH,NH, 0,0,0, 1);
        nop("t5e", 0, HM, NH, 0, 0, 1);
        // load-use pending under 5 busy cycles: wait first, timeout, then bubble
        cyc("t6a", 2,1, 0,0, 11,1,1, 0,0,0,0, NH,NH, 0,0,0, 1);
        cyc("t6b", 11,1, 0,1, 12,1,0, 0,1,0,0, NH,NH, 1,0,0, 1);
        cyc("t6c", 11,1, 0,1, 12,1,0, 0,1,0,0, NH,NH, 1,0,0, 1);
        cyc("t6d", 11,1, 0,1, 12,1,0, 0,1,0,0, NH,NH, 1,0,0, 1);
        cyc("t6e", 11,1, 0,1, 12,1,0, 0,1,0,0, NH,NH, 1,0,0, 1);
        cyc("t6f", 11,1, 0,1, 12,1,0, 0,1,0,0, NH,NH, 1,0,1, 1);
        cyc("t6g", 11,1, 0,1, 12,1,0, 0,0,0,0, NH,NH, 0,1,1, 1);
        cyc("t6h", 11,1, 0,1, 12,1,0, 0,0,0,0, NH,NH, 0,0,1, 1);
        nop("t6i", 0, HM, NH, 0, 1, 1);
        // load-use killed by jmp_purge
        cyc("t7a", 0,0, 0,0, 13,1,1, 0,0,0,0, NH,NH, 0,0,1, 1);
        cyc("t7b", 13,1, 13,1, 14,1,0, 1,0,0,0, NH,NH, 0,0,1, 1);
        nop("t7c", 0, NH, NH, 0, 1, 0);
        // rst_pipe during LDUSE
        cyc("t8a", 13,1, 0,0, 15,1,1, 0,0,0,0, NH,NH, 0,0,1, 1);
        cyc("t8b", 15,1, 0,0, 16,1,0, 0,0,0,0, HW,NH, 0,1,1, 1);
        cyc("t8c", 15,1, 0,0, 16,1,0, 0,0,1,0, HW,NH, 0,0,1, 1);
        cyc("t8d", 15,1, 0,0, 16,1,0, 0,0,0,0, NH,NH, 0,0,1, 1);
        nop("t8e", 0, NH, NH, 0, 1, 1);
        // two writers of x20: youngest wins
        cyc("t9a", 0,0, 0,0, 20,1,0, 0,0,0,0, NH,NH, 0,0,1, 1);
        cyc("t9b", 0,0, 0,0, 20,1,0, 0,0,0,0, NH,NH, 0,0,1, 1);
        cyc("t9c", 20,1, 20,1, 21,1,0, 0,0,0,0, NH,NH, 0,0,1, 1);
        cyc("t9d", 21,1, 20,1, 23,1,0, 0,0,0,0, HE,HE, 0,0,1, 1);
        // async reset in MWAIT
        nop("ta", 1, HE, HM, 1, 1, 1);
        cyc("tb", 0,0, 0,0, 0,0,0, 0,0,0,1, NH,NH, 0,0,0, 1);
        nop("tc", 0, NH, NH, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
